// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
// Shared constants for the pipelined adder/subtractor slice of the codebase.
//   DEFAULT_WIDTH  : default operand width in bits
//   DEFAULT_STAGES : default number of pipeline stages
//   mode_e         : operation select, MODE_ADD = 0, MODE_SUB = 1
// ----------------------------------------------------------------------------
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

endpackage

// File: rtl/adder_slice.sv
// ----------------------------------------------------------------------------
// adder_slice
// Purely combinational SW-bit ripple-carry adder built from full adders.
// Ports:
//   i_a, i_b : SW-bit operands
//   i_cin    : carry into bit 0
//   o_sum    : SW-bit sum
//   o_cout   : carry out of bit SW-1
// ----------------------------------------------------------------------------
module adder_slice
    import adder_pkg::*;
#(
    parameter int SW = 4
) (
    input  logic [SW-1:0] i_a,
    input  logic [SW-1:0] i_b,
    input  logic          i_cin,
    output logic [SW-1:0] o_sum,
    output logic          o_cout
);

    logic [SW:0] w_carry;

    // Classic ripple chain: each bit produces its sum and the carry for the
    // next bit up; w_carry[i] is the carry entering bit i.
    always_comb begin
        w_carry    = '0;
        o_sum      = '0;
        w_carry[0] = i_cin;
        for (int i = 0; i < SW; i++) begin
            o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
            w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout = w_carry[SW];

endmodule

// File: rtl/pipelined_adder_sub.sv
// ----------------------------------------------------------------------------
// pipelined_adder_sub
// Valid/ready pipelined adder/subtractor. Each of the STAGES stages adds one
// WIDTH/STAGES-bit slice; unconsumed operand bits travel forward with the
// operation and finished result slices accumulate alongside it, so the whole
// result emerges together after exactly STAGES cycles.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready = !out_valid || out_ready)
//   A, B                : WIDTH-bit operands
//   C_in                : carry-in, add mode only
//   SUB                 : 0 -> A+B+C_in, 1 -> A-B (as A+~B+1)
//   out_valid/out_ready : output handshake
//   S_out               : sum or difference
//   C_out               : carry out of the MSB (1 = no borrow when subtracting)
//   OVF                 : two's-complement signed overflow
// ----------------------------------------------------------------------------
module pipelined_adder_sub
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S_out,
    output logic             C_out,
    output logic             OVF
);

    localparam int SW = WIDTH / STAGES;

    if ((WIDTH % STAGES) != 0 || WIDTH < 4) begin : g_paramCheck
        $error("pipelined_adder_sub: WIDTH must be >= 4 and a multiple of STAGES");
    end

    logic             w_adv;
    logic             w_isSub;
    logic             w_cEff;
    logic [WIDTH-1:0] w_bEff;

    // Subtraction is folded into addition up front so every stage is a plain
    // adder: invert B and force the carry-in, ignoring C_in.
    assign w_isSub = (mode_e'(SUB) == MODE_SUB);
    assign w_bEff  = w_isSub ? ~B : B;
    assign w_cEff  = w_isSub ? 1'b1 : C_in;

    // The whole pipeline moves as one unit; a stalled output freezes it all,
    // bubbles included.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO   = k * SW;
        localparam int REST = WIDTH - LO;

        logic [REST-1:0]    w_aIn;
        logic [REST-1:0]    w_bIn;
        logic               w_cIn;
        logic               w_load;
        logic [SW-1:0]      w_sliceSum;
        logic               w_sliceCout;
        logic [LO+SW-1:0]   w_sumNext;
        logic               r_valid;
        logic               r_carry;
        logic [LO+SW-1:0]   r_sum;

        // Stage 0 takes the live inputs; later stages take whatever the
        // previous stage carried forward.
        if (k == 0) begin : g_src
            assign w_aIn     = A;
            assign w_bIn     = w_bEff;
            assign w_cIn     = w_cEff;
            assign w_load    = in_valid;
            assign w_sumNext = w_sliceSum;
        end else begin : g_src
            assign w_aIn     = g_stage[k-1].g_keep.r_aRest;
            assign w_bIn     = g_stage[k-1].g_keep.r_bRest;
            assign w_cIn     = g_stage[k-1].r_carry;
            assign w_load    = g_stage[k-1].r_valid;
            assign w_sumNext = {w_sliceSum, g_stage[k-1].r_sum};
        end

        adder_slice #(
            .SW(SW)
        ) u_slice (
            .i_a    (w_aIn[SW-1:0]),
            .i_b    (w_bIn[SW-1:0]),
            .i_cin  (w_cIn),
            .o_sum  (w_sliceSum),
            .o_cout (w_sliceCout)
        );

        // Valid bit shifts on every advance; data registers only load when a
        // real operation arrives, so outputs keep their last value across
        // bubbles.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_sum   <= '0;
            end else if (w_adv) begin
                r_valid <= w_load;
                if (w_load) begin
                    r_carry <= w_sliceCout;
                    r_sum   <= w_sumNext;
                end
            end
        end

        // Operand bits above this stage's slice ride along to later stages.
        if (k < STAGES - 1) begin : g_keep
            logic [REST-SW-1:0] r_aRest;
            logic [REST-SW-1:0] r_bRest;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_aRest <= '0;
                    r_bRest <= '0;
                end else if (w_adv && w_load) begin
                    r_aRest <= w_aIn[REST-1:SW];
                    r_bRest <= w_bIn[REST-1:SW];
                end
            end
        end

        // The carry into the MSB is recovered as a^b^sum at that bit, so the
        // overflow flag is that carry XOR the carry leaving the MSB.
        if (k == STAGES - 1) begin : g_last
            logic r_ovf;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_adv && w_load) begin
                    r_ovf <= w_aIn[SW-1] ^ w_bIn[SW-1] ^ w_sliceSum[SW-1] ^ w_sliceCout;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_valid;
    assign S_out     = g_stage[STAGES-1].r_sum;
    assign C_out     = g_stage[STAGES-1].r_carry;
    assign OVF       = g_stage[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// ----------------------------------------------------------------------------
// tb_pipelined_adder_sub
// Self-checking bench for pipelined_adder_sub. Three instances: the default
// 16-bit/4-stage block, a 16-bit/1-stage block and a 32-bit/8-stage block.
// Expected results come from an arithmetic reference model (integer add and
// subtract with explicit range checks for carry and signed overflow).
// ----------------------------------------------------------------------------
module tb_pipelined_adder_sub;

    logic        clk;
    logic        rst;

    logic        inValid, inReady, outValid, outReady;
    logic [15:0] a, b, sOut;
    logic        cIn, sub, cOut, ovf;

    logic        inValid1, inReady1, outValid1, cOut1, ovf1;
    logic [15:0] sOut1;

    logic        inValid8, inReady8, outValid8, cOut8, ovf8;
    logic [31:0] a8, b8, sOut8;

    int          assertionCount = 0;
    int          failCount = 0;
    bit          monitorOn = 0;
    bit          accepted = 0;
    int          sent = 0;
    int          received = 0;
    logic [17:0] expQ[$];

    pipelined_adder_sub #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
        .A(a), .B(b), .C_in(cIn), .SUB(sub),
        .out_valid(outValid), .out_ready(outReady),
        .S_out(sOut), .C_out(cOut), .OVF(ovf)
    );

    pipelined_adder_sub #(.WIDTH(16), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(inValid1), .in_ready(inReady1),
        .A(a), .B(b), .C_in(cIn), .SUB(sub),
        .out_valid(outValid1), .out_ready(outReady),
        .S_out(sOut1), .C_out(cOut1), .OVF(ovf1)
    );

    pipelined_adder_sub #(.WIDTH(32), .STAGES(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(inValid8), .in_ready(inReady8),
        .A(a8), .B(b8), .C_in(cIn), .SUB(sub),
        .out_valid(outValid8), .out_ready(outReady),
        .S_out(sOut8), .C_out(cOut8), .OVF(ovf8)
    );

    // 100 MHz-style free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertionCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: plain integer arithmetic; returns {overflow, carry, result}.
    function automatic logic [17:0] modelOp(input logic [15:0] opA, input logic [15:0] opB,
                                            input logic carryIn, input logic isSub);
        int          ua, ub, sa, sb, ures, sres;
        logic        carry, overflow;
        logic [15:0] res;
        ua = int'(opA);
        ub = int'(opB);
        sa = int'($signed(opA));
        sb = int'($signed(opB));
        if (isSub) begin
            ures  = ua - ub;
            carry = (ua >= ub);
            sres  = sa - sb;
        end else begin
            ures  = ua + ub + int'(carryIn);
            carry = (ures > 65535);
            sres  = sa + sb + int'(carryIn);
        end
        res      = ures[15:0];
        overflow = (sres > 32767) || (sres < -32768);
        return {overflow, carry, res};
    endfunction

    // Sends one operation into the 4-stage block with no backpressure, then
    // checks latency, result, and that the output holds once valid drops.
    task automatic applyStimulus(input string tag, input logic [15:0] av, input logic [15:0] bv,
                                 input logic cv, input logic sv, input logic [15:0] expS,
                                 input logic expC, input logic expO);
        int lat;
        @(posedge clk); #1;
        a = av; b = bv; cIn = cv; sub = sv; inValid = 1'b1; outReady = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        lat = 1;
        while (!outValid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, 4);
        checkOutput({tag, "_sum"}, sOut, expS);
        checkOutput({tag, "_cout"}, cOut, expC);
        checkOutput({tag, "_ovf"}, ovf, expO);
        @(posedge clk); #1;
        checkOutput({tag, "_validDrop"}, outValid, 0);
        checkOutput({tag, "_hold"}, sOut, expS);
    endtask

    // Mid-cycle monitor for the random stream: handshake rule, scoreboard.
    always @(negedge clk) begin
        if (monitorOn) begin
            checkOutput("inReadyRule", inReady, !outValid || outReady);
            accepted = inValid && inReady;
            if (inValid && inReady) begin
                expQ.push_back(modelOp(a, b, cIn, sub));
                sent++;
            end
            if (outValid && outReady) begin
                received++;
                if (expQ.size() == 0) begin
                    checkOutput("queueDepthAtOut", expQ.size(), 1);
                end else begin
                    checkOutput("streamResult", {ovf, cOut, sOut}, expQ.pop_front());
                end
            end
        end
    end

    initial begin
        int          lat1, lat8, cycles;
        logic [17:0] res1;
        logic [33:0] res8;
        bit          sawOut;

        rst = 1'b1; inValid = 1'b0; inValid1 = 1'b0; inValid8 = 1'b0;
        a = '0; b = '0; cIn = 1'b0; sub = 1'b0; a8 = '0; b8 = '0; outReady = 1'b0;
        #12;
        checkOutput("rstOutValid", outValid, 0);
        checkOutput("rstSum", sOut, 0);
        checkOutput("rstCout", cOut, 0);
        checkOutput("rstOvf", ovf, 0);
        checkOutput("rstInReady", inReady, 1);
        @(negedge clk);
        rst = 1'b0;

        // Same wrap-around addition through the 1-stage and 8-stage variants.
        outReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("inReady1", inReady1, 1);
        checkOutput("inReady8", inReady8, 1);
        a = 16'hFFFF; b = 16'h0001; cIn = 1'b0; sub = 1'b0;
        a8 = 32'hFFFF_FFFF; b8 = 32'h0000_0001;
        inValid1 = 1'b1; inValid8 = 1'b1;
        lat1 = 0; lat8 = 0; res1 = '0; res8 = '0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            inValid1 = 1'b0; inValid8 = 1'b0;
            if (outValid1 && lat1 == 0) begin
                lat1 = cyc;
                res1 = {ovf1, cOut1, sOut1};
            end
            if (outValid8 && lat8 == 0) begin
                lat8 = cyc;
                res8 = {ovf8, cOut8, sOut8};
            end
        end
        checkOutput("stages1Latency", lat1, 1);
        checkOutput("stages1Result", res1, 18'h1_0000);
        checkOutput("stages8Latency", lat8, 8);
        checkOutput("stages8Result", res8, 34'h1_0000_0000);

        // Directed corner cases on the default block.
        applyStimulus("addWrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus("subOvf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        applyStimulus("subBorrow", 16'h0001, 16'h0002, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        applyStimulus("addCinOvf", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        applyStimulus("subIgnoresCin", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);

        // Random stream with random backpressure.
        sent = 0; received = 0; cycles = 0; accepted = 1'b0;
        inValid = 1'b0;
        monitorOn = 1'b1;
        while (received < 100 && cycles < 5000) begin
            @(posedge clk); #1;
            cycles++;
            outReady = 1'($urandom_range(0, 1));
            if (!inValid || accepted) begin
                if (sent < 100 && $urandom_range(0, 3) != 0) begin
                    a = 16'($urandom); b = 16'($urandom);
                    cIn = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                    inValid = 1'b1;
                end else begin
                    inValid = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        monitorOn = 1'b0;
        inValid = 1'b0;
        checkOutput("streamReceived", received, 100);
        checkOutput("streamLeftover", expQ.size(), 0);
        expQ.delete();

        // Reset with four operations queued behind a stalled output.
        outReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            a = 16'($urandom); b = 16'($urandom); sub = 1'b0; cIn = 1'b0;
            inValid = 1'b1;
        end
        @(posedge clk); #1;
        inValid = 1'b0;
        checkOutput("preRstValid", outValid, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstOutValid", outValid, 0);
        checkOutput("midRstSum", sOut, 0);
        checkOutput("midRstCout", cOut, 0);
        checkOutput("midRstOvf", ovf, 0);
        checkOutput("midRstInReady", inReady, 1);
        @(negedge clk);
        rst = 1'b0;
        outReady = 1'b1;
        sawOut = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (outValid) sawOut = 1'b1;
        end
        checkOutput("noStaleOut", sawOut, 0);
        applyStimulus("afterRst", 16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failCount);
        $finish;
    end

endmodule
